// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID register and one-entry skid.
//
// Keeps exactly one instruction-memory request outstanding. A redirect
// restarts fetch at a new PC. A request that is still in flight when the
// redirect arrives is drained, and its response is thrown away.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   stall        decode cannot accept; the IF/ID outputs hold
//   redirect     taken branch; flush and refetch from redirect_pc
//   redirect_pc  branch target (bits[1:0] ignored)
//   imem_req     request valid toward instruction memory
//   imem_addr    word-aligned byte address of the request
//   imem_ready   response valid; completes the request when imem_req=1
//   imem_rdata   instruction word, valid with imem_ready
//   inst_out     IF/ID instruction
//   incinst_out  IF/ID PC+4 of inst_out
//   inst_valid   IF/ID holds a live instruction (0 = bubble)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one dead cycle after reset, no request
// REQ   | request at pc outstanding, waiting for imem_ready
// HOLD  | word captured in skid while decode stalls, no request
// DRAIN | pre-redirect request still in flight, its response is dropped

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] incinst_out,
    output logic        inst_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] skid_inst;
    logic [31:0] skid_inc;
    logic [31:0] pc_inc;
    logic [31:0] redirect_target;

    assign pc_inc          = pc + 32'd4;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
    // While draining, pc already points at the redirect target, so the
    // address of the in-flight request is kept separately.
    assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            drain_addr  <= 32'd0;
            skid_inst   <= 32'd0;
            skid_inc    <= 32'd0;
            inst_out    <= 32'd0;
            incinst_out <= 32'd0;
            inst_valid  <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_target;
            inst_valid <= 1'b0;
            case (state)
                S_REQ: begin
                    if (!imem_ready) begin
                        drain_addr <= pc;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    // IDLE or HOLD: a held skid word is simply abandoned.
                    state <= S_REQ;
                end
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    if (!stall) begin
                        inst_valid <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (imem_ready) begin
                        pc <= pc_inc;
                        if (!stall) begin
                            inst_out    <= imem_rdata;
                            incinst_out <= pc_inc;
                            inst_valid  <= 1'b1;
                        end else begin
                            skid_inst <= imem_rdata;
                            skid_inc  <= pc_inc;
                            state     <= S_HOLD;
                        end
                    end else if (!stall) begin
                        inst_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_out    <= skid_inst;
                        incinst_out <= skid_inc;
                        inst_valid  <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    if (imem_ready) begin
                        state <= S_REQ;
                    end
                    if (!stall) begin
                        inst_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
